// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled step tick driving RUN/BOUNCE/BLINK/COUNT patterns,
// mode changes via req/ack handshake. Optional build macro: LED_ACTIVE_LOW_EN.
module led_pattern_ctrl #(
    parameter int          N       = 6,
    parameter logic [31:0] TIMEOUT = 32'h05,
    parameter int          CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode_req,
    input  logic [1:0]   mode_sel,
    input  logic         pause,
    output logic         mode_ack,
    output logic [1:0]   mode_cur,
    output logic         tick,
    output logic [N-1:0] led,
    output logic         dbg_state
);

    // Handshake: mode_req/mode_sel are sampled while in ACCEPT; the accepting edge
    // raises mode_ack for one cycle. mode_req must then be seen low before another accept.
    typedef enum logic {ST_ACCEPT = 1'b0, ST_ACKED = 1'b1} hs_state_e;

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;

    localparam logic [CNT_W-1:0] TO_EFF   = (TIMEOUT == 32'd0) ? CNT_W'(1) : CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EFF - CNT_W'(1);

    hs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     pat_q, pat_d, pat_step;
    logic             dir_q, dir_d, dir_step;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             accept;
    logic             step;

    function automatic logic [N-1:0] init_pat(input logic [1:0] m);
        case (m)
            MODE_BLINK: init_pat = '1;
            2'd3:       init_pat = '0;
            default:    init_pat = N'(1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_ACCEPT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (mode_req)  state_d = ST_ACKED;
            default:   if (!mode_req) state_d = ST_ACCEPT;
        endcase
    end

    always_comb begin
        accept    = (state_q == ST_ACCEPT) && mode_req;
        dbg_state = state_q;
    end

    assign step = !pause && (cnt_q == CNT_LAST);

    // BOUNCE flips direction on the step that leaves an end bit.
    always_comb begin
        pat_step = pat_q;
        dir_step = dir_q;
        case (mode_q)
            MODE_RUN: pat_step = (pat_q << 1) | (pat_q >> (N - 1));
            MODE_BOUNCE: begin
                if (N > 1) begin
                    if (dir_q) begin
                        if (pat_q[N-1]) begin
                            pat_step = pat_q >> 1;
                            dir_step = 1'b0;
                        end else begin
                            pat_step = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            pat_step = pat_q << 1;
                            dir_step = 1'b1;
                        end else begin
                            pat_step = pat_q >> 1;
                        end
                    end
                end
            end
            MODE_BLINK: pat_step = ~pat_q;
            default:    pat_step = pat_q + N'(1);
        endcase
    end

    // Accept outranks a coincident step: reload, no advance, prescaler restarts.
    always_comb begin
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        ack_d  = accept;
        if (accept) begin
            cnt_d  = '0;
            mode_d = mode_sel;
            pat_d  = init_pat(mode_sel);
            dir_d  = 1'b1;
        end else if (!pause) begin
            if (step) begin
                cnt_d  = '0;
                pat_d  = pat_step;
                dir_d  = dir_step;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            pat_q  <= N'(1);
            dir_q  <= 1'b1;
            mode_q <= MODE_RUN;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
        end
    end

    assign mode_ack = ack_q;
    assign mode_cur = mode_q;
    assign tick     = tick_q;

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~pat_q;
`else
    assign led = pat_q;
`endif

endmodule
